iiitb_sipo_rx: RTL and testbench
================================

// Module: iiitb_sipo_rx
// PURPOSE
//  Serial-in/parallel-out frame receiver, downstream of the 4-bit PISO shifter.
//  Consumes a 1-bit-per-clock, LSB-first stream (line idles high) and recovers words.
//  Frame: start(0), DATA_W data bits, [parity], stop(1).
//  Delivers each word over a valid/ready handshake and flags frame/overrun errors.
// PARAMETERS
//  DATA_W   4   data bits per frame (legal range 2..16)
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  rst_n       in   1       asynchronous active-low reset
//  serial_in   in   1       serial line, one bit per clk, idle = 1
//  rx_data     out  DATA_W  received word, bit 0 = first data bit on the line
//  rx_valid    out  1       rx_data holds an unconsumed word
//  rx_ready    in   1       consumer accepts; transfer when rx_valid & rx_ready
//  frame_err   out  1       1-cycle pulse: stop bit sampled 0
//  overrun     out  1       1-cycle pulse: word completed while rx_valid & ~rx_ready
//  parity_err  out  1       1-cycle pulse: parity mismatch (tied 0 if no RX_PARITY_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, bit count=0, shift reg=0, rx_data=0.
//   rx_valid=0, frame_err=0, overrun=0, parity_err=0; mid-frame reset discards frame.
//  FSM, one transition per clk:
//   IDLE: serial_in=0 -> DATA (count=0); else stay.
//   DATA: shift serial_in into MSB of shift reg (right shift); count++.
//    After DATA_W bits -> PARITY if RX_PARITY_EN, else STOP.
//   PARITY: compare serial_in to even parity of the data bits -> STOP.
//   STOP: serial_in=1 -> commit word, go to IDLE.
//    serial_in=0 -> frame_err pulse, discard word, go to BREAK.
//   BREAK: wait for serial_in=1 -> IDLE (a 0 is never taken as a new start here).
//  Commit: rx_data<=shift reg, rx_valid<=1 on the clk after the stop bit is sampled.
//   Latency from start-bit sample to rx_valid=1: DATA_W+2 clk (+1 with parity).
//  Back-to-back frames: start bit may be sampled on the clk right after the stop bit.
//  Handshake: rx_valid stays 1 and rx_data stays stable until rx_valid & rx_ready.
//   rx_valid then drops the next clk, unless a commit happens in that same clk.
//   Simultaneous accept + commit: rx_valid stays 1 and rx_data takes the new word.
//   Commit while rx_valid & ~rx_ready: new word dropped, old word kept, overrun pulse.
//  Parity error: word is still committed; parity_err pulses alongside the commit.
//  Frame with both errors: frame_err only; parity_err is suppressed.
//  All error outputs are registered, high for exactly one clk.
// CONFIGURATION
//  RX_PARITY_EN defined: PARITY state present; frame = DATA_W+3 bits.
//   parity_err live; parity is even (parity bit = ^data).
//  RX_PARITY_EN undefined: no PARITY state; frame = DATA_W+2 bits; parity_err = 0.
// STRUCTURE
//  Package iiitb_serial_pkg holds:
//   - state encoding localparams: IDLE, DATA, PARITY, STOP, BREAK
//   - line level constants: LINE_IDLE=1, START_BIT=0, STOP_BIT=1
//   - default DATA_W=4, shared with the PISO side
//  Sub-module iiitb_rx_holdreg: output word register + valid/ready + overrun logic.
//   The FSM and shifter stay in the top module.
// TESTING
//  1. Reset then idle line, 20 clk -> rx_valid=0, all error pulses 0.
//  2. DATA_W=4, frame 0,1,0,1,1,1 with rx_ready=1.
//     -> rx_data=4'b1101 (bits LSB first), rx_valid=1 exactly 6 clk after start sample, 1 clk wide.
//  3. Two back-to-back frames 4'hA then 4'h5, rx_ready=0 throughout.
//     -> rx_data stays 4'hA, overrun pulses once at the second commit.
//  4. Frame 4'h3 with stop bit 0, then line held 0 for 3 clk, then 1.
//     -> frame_err pulses once, no commit, no false start until line returns to 1.
//  5. rst_n pulsed low for 1 clk after the 2nd data bit.
//     -> outputs 0 immediately; next full frame 4'h9 is received correctly.
//  6. RX_PARITY_EN: frame 4'h7 with parity bit 0 (expected 1).
//     -> rx_data=4'h7 committed, parity_err pulses with rx_valid rising.

Source files
------------

// File: rtl/iiitb_serial_pkg.sv
// Shared definitions for the serial link: receiver state encoding, line levels, default width.
// Used by iiitb_sipo_rx, which has the RX_PARITY_EN build option.
package iiitb_serial_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DATA   = 3'd1;
  localparam logic [2:0] PARITY = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StData   = DATA,
    StParity = PARITY,
    StStop   = STOP,
    StBreak  = BREAK
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // The PISO transmitter uses the same default word width.
  localparam int unsigned DEFAULT_DATA_W = 4;
  localparam int unsigned MIN_DATA_W     = 2;
  localparam int unsigned MAX_DATA_W     = 16;

endpackage

// File: rtl/iiitb_rx_holdreg.sv
// Output word register for the SIPO receiver: valid/ready handshake and overrun detection.
module iiitb_rx_holdreg #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              rx_ready_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (commit_i) begin
      // A word still waiting for its consumer wins; the new one is lost.
      if (valid_q && !rx_ready_i) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = word_i;
        valid_d = 1'b1;
      end
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/iiitb_sipo_rx.sv
// Serial-in/parallel-out frame receiver: start, DATA_W bits LSB first, optional even parity, stop.
// Define RX_PARITY_EN to include the parity bit and a live parity_err output.
module iiitb_sipo_rx
  import iiitb_serial_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              commit_q, commit_d;
  logic              frame_err_q, frame_err_d;

`ifdef RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    commit_d    = 1'b0;
    frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (serial_in == START_BIT) begin
          state_d = StData;
          cnt_d   = '0;
`ifdef RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      StData: begin
        // Right shift: after DATA_W bits the first bit received sits in bit 0.
        shift_d = {serial_in, shift_q[DATA_W-1:1]};
        if (cnt_q == LastBit) begin
          cnt_d = '0;
`ifdef RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
`ifdef RX_PARITY_EN
        par_bad_d = (serial_in != ^shift_q);
`endif
        state_d = StStop;
      end
      StStop: begin
        if (serial_in == STOP_BIT) begin
          commit_d = 1'b1;
          state_d  = StIdle;
        end else begin
          frame_err_d = 1'b1;
          state_d     = StBreak;
        end
      end
      StBreak: begin
        // A held-low line is a break, not a new start bit.
        if (serial_in == LINE_IDLE) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef RX_PARITY_EN
  // Raised on the same edge the hold register loads, so it lines up with rx_valid rising.
  always_comb begin
    parity_err_d = commit_q & par_bad_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign frame_err = frame_err_q;

  // shift_q is still intact here: the next frame's first data bit shifts one clk later.
  iiitb_rx_holdreg #(
    .DATA_W (DATA_W)
  ) u_holdreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .commit_i   (commit_q),
    .word_i     (shift_q),
    .rx_ready_i (rx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .overrun_o  (overrun)
  );

endmodule

// File: tb/tb_iiitb_sipo_rx.sv
// Scoreboard bench for iiitb_sipo_rx: directed frames plus randomized traffic.
module tb_iiitb_sipo_rx;

  localparam int unsigned DW = 4;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          serial_in;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  int checks = 0;
  int fails  = 0;
  int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  int obs_ferr = 0, obs_ovr = 0, obs_perr = 0;
  logic [DW-1:0] exp_q[$];

  iiitb_sipo_rx #(
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a good frame yields its word unless it lands on an unread word.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_ok, input logic par_ok,
                            input logic drop);
    if (!stop_ok) begin
      exp_ferr++;
    end else begin
      if (PAR_EN && !par_ok) exp_perr++;
      if (drop) exp_ovr++;
      else exp_q.push_back(d);
    end
    send_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) send_bit(d[i]);
    if (PAR_EN) send_bit(par_ok ? ^d : ~^d);
    send_bit(stop_ok);
    serial_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err_cnt"}, 32'(obs_ferr), 32'(exp_ferr));
    check({tag, "_overrun_cnt"}, 32'(obs_ovr), 32'(exp_ovr));
    check({tag, "_parity_err_cnt"}, 32'(obs_perr), 32'(exp_perr));
  endtask

  // Monitor: counts error pulses and pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) obs_ferr++;
      if (overrun) obs_ovr++;
      if (parity_err) obs_perr++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected no word at %0t", rx_data, $time);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    logic          stop_ok, par_ok;
    int            gap, brk, waited;

    rst_n     = 1'b0;
    serial_in = 1'b1;
    rx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;

    // 1: idle line produces nothing
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1);
      check("idle_rx_valid", 32'(rx_valid), 32'd0);
      check("idle_errs", 32'({frame_err, overrun, parity_err}), 32'd0);
    end

    // 2: single frame, latency and one-cycle valid with rx_ready high
    send_frame(4'b1101, 1'b1, 1'b1, 1'b0);
    check("lat_valid_early", 32'(rx_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid_rise", 32'(rx_valid), 32'd1);
    check("lat_data", 32'(rx_data), 32'hD);
    @(posedge clk); #1;
    check("lat_valid_fall", 32'(rx_valid), 32'd0);
    idle(3);
    check_counts("t2");

    // 3: back-to-back frames with the consumer stalled
    rx_ready = 1'b0;
    send_frame(4'hA, 1'b1, 1'b1, 1'b0);
    send_frame(4'h5, 1'b1, 1'b1, 1'b1);
    idle(4);
    check("ovr_hold_valid", 32'(rx_valid), 32'd1);
    check("ovr_hold_data", 32'(rx_data), 32'hA);
    check_counts("t3");
    rx_ready = 1'b1;
    idle(3);
    check("ovr_drained", 32'(exp_q.size()), 32'd0);
    check("ovr_valid_drop", 32'(rx_valid), 32'd0);

    // 4: bad stop bit followed by a held-low break
    send_frame(4'h3, 1'b0, 1'b1, 1'b0);
    repeat (3) send_bit(1'b0);
    idle(12);
    check("brk_no_valid", 32'(rx_valid), 32'd0);
    check_counts("t4");
    send_frame(4'h6, 1'b1, 1'b1, 1'b0);
    idle(4);

    // 5: reset pulse in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(rx_data), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_errs", 32'({frame_err, overrun, parity_err}), 32'd0);
    serial_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    send_frame(4'h9, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("rst_drained", 32'(exp_q.size()), 32'd0);
    check_counts("t5");

`ifdef RX_PARITY_EN
    // 6: parity error still commits, pulse aligned with rx_valid
    send_frame(4'h7, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("par_valid", 32'(rx_valid), 32'd1);
    check("par_err_pulse", 32'(parity_err), 32'd1);
    check("par_data", 32'(rx_data), 32'h7);
    idle(3);
    check_counts("t6");
`endif

    // Randomized traffic with rx_ready held high
    for (int n = 0; n < 60; n++) begin
      d       = DW'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      par_ok  = ($urandom_range(0, 3) != 0);
      gap     = $urandom_range(0, 3);
      brk     = $urandom_range(0, 3);
      send_frame(d, stop_ok, par_ok, 1'b0);
      if (!stop_ok) begin
        repeat (brk) send_bit(1'b0);
        send_bit(1'b1);
      end
      idle(gap);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      idle(1);
      waited++;
    end
    idle(3);
    check("final_drain", 32'(exp_q.size()), 32'd0);
    check_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
